// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD/MMC command-line transmitter.
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    CRC,
    END,
    GAP
  } state_t;

  localparam int unsigned HDR_BITS   = 40;
  localparam int unsigned CRC_BITS   = 7;
  localparam int unsigned FRAME_BITS = 48;

  localparam logic [CRC_BITS-1:0] CRC7_POLY = 7'h09;

  // One serial CRC-7 step (x^7 + x^3 + 1) for input bit d.
  function automatic logic [CRC_BITS-1:0] crc7_step(input logic [CRC_BITS-1:0] c, input logic d);
    logic inv;
    inv = d ^ c[CRC_BITS-1];
    return {c[CRC_BITS-2:0], 1'b0} ^ (inv ? CRC7_POLY : '0);
  endfunction

endpackage

// File: rtl/crc7_lfsr.sv
// Serial CRC-7 engine with synchronous clear; holds its value when en is low.
module crc7_lfsr
  import sd_cmd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                d,
  output logic [CRC_BITS-1:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc7_step(crc, d);
    end
  end

endmodule

// File: rtl/sd_cmd_tx_ctrl.sv
// SD/MMC CMD-line transmitter: serialises start/dir/index/arg, CRC-7 and end bit,
// then holds the line released for GAP_BITS strobes before accepting the next command.
module sd_cmd_tx_ctrl
  import sd_cmd_pkg::*;
#(
  parameter int unsigned GAP_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_en,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [5:0]          cmd_index,
  input  logic [31:0]         cmd_arg,
  input  logic                abort,
  output logic                sd_cmd_o,
  output logic                sd_cmd_oe,
  output logic                done,
  output logic [CRC_BITS-1:0] crc_o
);

  localparam logic [5:0] HDR_LAST = 6'(HDR_BITS - 1);
  localparam logic [5:0] CRC_LAST = 6'(CRC_BITS - 1);
  localparam logic [5:0] GAP_LIM  = 6'(GAP_BITS);

  state_t                state;
  logic [HDR_BITS-1:0]   hdr_sr;
  logic [5:0]            bit_cnt;
  logic [5:0]            gap_cnt;
  logic [5:0]            gap_nxt;
  logic [2:0]            crc_idx;
  logic                  crc_clr;
  logic                  crc_en;
  logic                  in_frame;
  logic [CRC_BITS-1:0]   crc;

  always_comb begin
    in_frame = (state == HEAD) || (state == CRC) || (state == END);
    crc_clr  = (state == IDLE) && cmd_valid && cmd_ready;
    crc_en   = (state == HEAD) && bit_en && !abort;
    gap_nxt  = gap_cnt + 6'd1;
    crc_idx  = 3'd6 - bit_cnt[2:0];
  end

  crc7_lfsr u_crc7 (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .d   (hdr_sr[HDR_BITS-1]),
    .crc (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hdr_sr    <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      cmd_ready <= 1'b0;
      sd_cmd_o  <= 1'b1;
      sd_cmd_oe <= 1'b0;
      done      <= 1'b0;
      crc_o     <= '0;
    end else begin
      done <= 1'b0;
      // abort outranks a coincident strobe and suppresses the done pulse
      if (abort && in_frame) begin
        state     <= GAP;
        sd_cmd_o  <= 1'b1;
        sd_cmd_oe <= 1'b0;
        bit_cnt   <= '0;
        gap_cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            cmd_ready <= 1'b1;
            if (cmd_valid && cmd_ready) begin
              hdr_sr    <= {1'b0, 1'b1, cmd_index, cmd_arg};
              bit_cnt   <= '0;
              cmd_ready <= 1'b0;
              state     <= HEAD;
            end
          end
          HEAD: if (bit_en) begin
            sd_cmd_o  <= hdr_sr[HDR_BITS-1];
            sd_cmd_oe <= 1'b1;
            hdr_sr    <= {hdr_sr[HDR_BITS-2:0], 1'b0};
            if (bit_cnt == HDR_LAST) begin
              // capture the final CRC in the same edge the engine absorbs the last bit
              crc_o   <= crc7_step(crc, hdr_sr[HDR_BITS-1]);
              bit_cnt <= '0;
              state   <= CRC;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          CRC: if (bit_en) begin
            sd_cmd_o <= crc[crc_idx];
            if (bit_cnt == CRC_LAST) begin
              bit_cnt <= '0;
              state   <= END;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          END: if (bit_en) begin
            sd_cmd_o <= 1'b1;
            done     <= 1'b1;
            gap_cnt  <= '0;
            state    <= GAP;
          end
          GAP: if (bit_en) begin
            sd_cmd_o  <= 1'b1;
            sd_cmd_oe <= 1'b0;
            gap_cnt   <= gap_nxt;
            if (gap_nxt == GAP_LIM) begin
              gap_cnt   <= '0;
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx_ctrl.sv
// Bench for sd_cmd_tx_ctrl: captures the serial CMD line and compares it against
// a polynomial-division CRC-7 reference and frame-level timing rules.
module tb_sd_cmd_tx_ctrl;
  import sd_cmd_pkg::*;

  localparam int unsigned GAP = 8;
  localparam int unsigned LIM = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_en = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        abort = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        cmd_ready, sd_cmd_o, sd_cmd_oe, done;
  logic [6:0]  crc_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned en_mode = 0;
  int unsigned cyc = 0;

  bit          cap[$];
  int unsigned oe_cycles = 0;
  int unsigned done_cnt = 0;
  int unsigned stall_viol = 0;
  logic        prev_en = 1'b0, prev_abort = 1'b0, prev_o = 1'b1, prev_oe = 1'b0;
  bit          skip = 1'b1;
  logic [6:0]  last_crc = '0;

  sd_cmd_tx_ctrl #(.GAP_BITS(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .abort     (abort),
    .sd_cmd_o  (sd_cmd_o),
    .sd_cmd_oe (sd_cmd_oe),
    .done      (done),
    .crc_o     (crc_o)
  );

  always #5 clk = ~clk;

  // bit_en pattern: 0 = every cycle, 1 = every 3rd cycle, 2 = random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (en_mode)
        0:       bit_en = 1'b1;
        1:       bit_en = (cyc % 3 == 0);
        default: bit_en = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Line monitor: a bit is emitted in the cycle after a strobe without abort.
  always @(negedge clk) begin
    if (rst) begin
      skip = 1'b1;
    end else begin
      if (!skip && !prev_en && !prev_abort && (sd_cmd_o !== prev_o || sd_cmd_oe !== prev_oe))
        stall_viol++;
      if (prev_en && !prev_abort && sd_cmd_oe) cap.push_back(sd_cmd_o);
      if (sd_cmd_oe) oe_cycles++;
      if (done) done_cnt++;
      skip = 1'b0;
    end
    prev_en    = bit_en;
    prev_abort = abort;
    prev_o     = sd_cmd_o;
    prev_oe    = sd_cmd_oe;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // CRC-7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] msg;
    msg = {2'b01, idx, arg};
    return {msg, ref_crc7(msg), 1'b1};
  endfunction

  task automatic wait_strobes(input int unsigned k, output bit ok);
    int unsigned sc = 0;
    ok = 1'b0;
    for (int unsigned n = 0; n < LIM; n++) begin
      if (bit_en) begin
        sc++;
        if (sc == k) ok = 1'b1;
      end
      if (ok) break;
      tick();
    end
  endtask

  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] exp_f,
                           input logic [6:0] exp_c, input int unsigned mode, input int unsigned abort_at,
                           input bit hold, input logic [5:0] h_idx, input logic [31:0] h_arg);
    int unsigned n, g, nb, cap_base, oe_base, done_base, viol_base;
    bit          ok, early;
    logic [47:0] f;
    en_mode = mode;
    n = 0;
    while (!cmd_ready && n < LIM) begin tick(); n++; end
    check("ready_before_accept", cmd_ready, 1'b1);
    cap_base  = cap.size();
    oe_base   = oe_cycles;
    done_base = done_cnt;
    viol_base = stall_viol;
    cmd_valid = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    tick();
    if (hold) begin
      cmd_index = h_idx;
      cmd_arg   = h_arg;
    end else begin
      cmd_valid = 1'b0;
    end
    if (abort_at != 0) begin
      wait_strobes(abort_at, ok);
      check("abort_strobe_reached", ok, 1'b1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_oe", sd_cmd_oe, 1'b0);
      check("abort_line", sd_cmd_o, 1'b1);
      nb = abort_at - 1;
      if (nb >= HDR_BITS) last_crc = exp_c;
    end else begin
      early = 1'b0;
      n = 0;
      while (!done && n < LIM) begin
        if (cmd_ready) early = 1'b1;
        tick();
        n++;
      end
      check("done_seen", done, 1'b1);
      check("ready_while_busy", early, 1'b0);
      nb = FRAME_BITS;
      last_crc = exp_c;
    end
    g = 0;
    n = 0;
    while (!cmd_ready && n < LIM) begin
      if (bit_en) g++;
      tick();
      n++;
    end
    check("gap_strobes", g, GAP);
    f = '0;
    for (int unsigned i = cap_base; i < cap.size(); i++) f = {f[46:0], cap[i]};
    check("bit_count", cap.size() - cap_base, nb);
    check("frame_bits", f, exp_f >> (FRAME_BITS - nb));
    check("crc_o", crc_o, last_crc);
    check("done_pulses", done_cnt - done_base, (abort_at == 0) ? 1 : 0);
    check("stall_hold", stall_viol - viol_base, 0);
    if (mode < 2 && abort_at == 0)
      check("oe_cycles", oe_cycles - oe_base, FRAME_BITS * ((mode == 1) ? 3 : 1));
  endtask

  initial begin
    logic [31:0] a;
    logic [5:0]  ix;
    int unsigned md, ab, n;
    bit          ok;

    tick();
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_line", sd_cmd_o, 1'b1);
    check("rst_oe", sd_cmd_oe, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_crc", crc_o, 7'h00);
    rst = 1'b0;
    check("ready_reset_cycle", cmd_ready, 1'b0);
    tick();
    check("ready_idle", cmd_ready, 1'b1);

    run_frame(6'd0, 32'h0, 48'h40_0000_0000_95, 7'h4A, 0, 0, 1'b0, '0, '0);
    run_frame(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87, 7'h43, 0, 0, 1'b1, 6'd17, 32'h0);
    run_frame(6'd17, 32'h0, 48'h51_0000_0000_55, 7'h2A, 0, 0, 1'b0, '0, '0);
    run_frame(6'd0, 32'h0, 48'h40_0000_0000_95, 7'h4A, 1, 0, 1'b0, '0, '0);

    a = $urandom;
    run_frame(6'd5, a, ref_frame(6'd5, a), ref_crc7({2'b01, 6'd5, a}), 0, 20, 1'b0, '0, '0);
    run_frame(6'd0, 32'h0, 48'h40_0000_0000_95, 7'h4A, 0, 0, 1'b0, '0, '0);

    // asynchronous reset in the middle of the CRC field
    en_mode = 0;
    n = 0;
    while (!cmd_ready && n < LIM) begin tick(); n++; end
    cmd_valid = 1'b1;
    cmd_index = 6'd17;
    cmd_arg   = 32'h0;
    tick();
    cmd_valid = 1'b0;
    wait_strobes(44, ok);
    check("rst_strobe_reached", ok, 1'b1);
    check("pre_rst_oe", sd_cmd_oe, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_oe", sd_cmd_oe, 1'b0);
    check("mid_rst_line", sd_cmd_o, 1'b1);
    check("mid_rst_ready", cmd_ready, 1'b0);
    check("mid_rst_crc", crc_o, 7'h00);
    tick();
    check("mid_rst_done", done, 1'b0);
    tick();
    rst = 1'b0;
    last_crc = '0;
    check("post_rst_ready_low", cmd_ready, 1'b0);
    tick();
    check("post_rst_ready_up", cmd_ready, 1'b1);
    run_frame(6'd17, 32'h0, 48'h51_0000_0000_55, 7'h2A, 0, 0, 1'b0, '0, '0);

    for (int k = 0; k < 10; k++) begin
      ix = 6'($urandom);
      a  = $urandom;
      md = $urandom_range(0, 2);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 48) : 0;
      run_frame(ix, a, ref_frame(ix, a), ref_crc7({2'b01, ix, a}), md, ab, 1'b0, '0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
